timing_fsm: RTL and testbench



---
 rtl/timing_fsm.sv | 161 ++++++++++++++++
 tb/tb_timing_fsm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/timing_fsm.sv
// rtl/timing_fsm.sv - per-bank DRAM timing state tracker with dwell down-counters
module timing_fsm #(
    parameter int BGWIDTH = 2,
    parameter int BAWIDTH = 2,
    parameter int BL      = 8,
    parameter int T_CL    = 17,
    parameter int T_RCD   = 17,
    parameter int T_WR    = 14,
    parameter int T_RP    = 17,
    parameter int T_RFC   = 34,
    localparam int BGW    = (BGWIDTH > 0) ? BGWIDTH : 1,
    localparam int NBG    = 1 << BGWIDTH,
    localparam int NBA    = 1 << BAWIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [BGW-1:0]     bg,
    input  logic [BAWIDTH-1:0] ba,
    input  logic [18:0]        commands,
    output logic [4:0]         BankFSM [0:NBG-1][0:NBA-1]
);

    // CAS latency only matters to the read data path, not to bank state
    localparam int unused_t_cl = T_CL;

    // Counter must hold the longest dwell minus one, never narrower than 8 bits
    localparam int M_A  = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int M_B  = (T_RFC > T_WR + 1) ? T_RFC : T_WR + 1;
    localparam int M_C  = (M_A > M_B) ? M_A : M_B;
    localparam int MAXN = (M_C > BL + 1) ? M_C : BL + 1;
    localparam int CW   = ($clog2(MAXN) > 8) ? $clog2(MAXN) : 8;

    localparam logic [CW-1:0] LD_RCD = CW'(T_RCD - 1);
    localparam logic [CW-1:0] LD_RP  = CW'(T_RP - 1);
    localparam logic [CW-1:0] LD_RFC = CW'(T_RFC - 1);
    localparam logic [CW-1:0] LD_RAP = CW'(BL);
    localparam logic [CW-1:0] LD_WAP = CW'(T_WR);

    typedef enum logic [4:0] {
        S_IDLE         = 5'h00,
        S_ACTIVATING   = 5'h01,
        S_BANK_ACTIVE  = 5'h03,
        S_PRECHARGING  = 5'h0a,
        S_READING      = 5'h0b,
        S_READING_AP   = 5'h0c,
        S_REFRESHING   = 5'h0d,
        S_WRITING      = 5'h12,
        S_WRITING_AP   = 5'h13
    } state_t;

    state_t          state [0:NBG-1][0:NBA-1];
    logic [CW-1:0]   cnt   [0:NBG-1][0:NBA-1];
    logic            sel   [0:NBG-1][0:NBA-1];

    logic c_act, c_pr, c_pra, c_rd, c_rda, c_ref, c_wr, c_wra;

    // Mode/power commands never change bank state; bg is meaningless on DDR3
    logic unused_inputs;
    assign unused_inputs = ^{commands[17:8], commands[2], bg};

    assign c_act = commands[18];
    assign c_pr  = commands[7];
    assign c_pra = commands[6];
    assign c_rd  = commands[5];
    assign c_rda = commands[4];
    assign c_ref = commands[3];
    assign c_wr  = commands[1];
    assign c_wra = commands[0];

    // Decode which bank the current bank-addressed command targets
    always_comb begin
        for (int g = 0; g < NBG; g++) begin
            for (int b = 0; b < NBA; b++) begin
                sel[g][b] = ((BGWIDTH == 0) || (bg == BGW'(g))) && (ba == BAWIDTH'(b));
            end
        end
    end

    // Per-bank state machine: command steering, priority and dwell timers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < NBG; g++) begin
                for (int b = 0; b < NBA; b++) begin
                    state[g][b] <= S_IDLE;
                    cnt[g][b]   <= '0;
                end
            end
        end else begin
            for (int g = 0; g < NBG; g++) begin
                for (int b = 0; b < NBA; b++) begin
                    case (state[g][b])
                        S_IDLE: begin
                            // PR/PRA are no-ops here, so REF still acts if they coincide
                            if (c_act && sel[g][b]) begin
                                state[g][b] <= S_ACTIVATING;
                                cnt[g][b]   <= LD_RCD;
                            end else if (c_ref) begin
                                state[g][b] <= S_REFRESHING;
                                cnt[g][b]   <= LD_RFC;
                            end
                        end
                        S_BANK_ACTIVE, S_READING, S_WRITING: begin
                            // ACT is illegal on an open bank, so PRA leads the chain
                            if (c_pra || (c_pr && sel[g][b])) begin
                                state[g][b] <= S_PRECHARGING;
                                cnt[g][b]   <= LD_RP;
                            end else if (c_rda && sel[g][b]) begin
                                state[g][b] <= S_READING_AP;
                                cnt[g][b]   <= LD_RAP;
                            end else if (c_rd && sel[g][b]) begin
                                state[g][b] <= S_READING;
                            end else if (c_wra && sel[g][b]) begin
                                state[g][b] <= S_WRITING_AP;
                                cnt[g][b]   <= LD_WAP;
                            end else if (c_wr && sel[g][b]) begin
                                state[g][b] <= S_WRITING;
                            end
                        end
                        S_ACTIVATING: begin
                            if (cnt[g][b] == '0) begin
                                state[g][b] <= S_BANK_ACTIVE;
                            end else begin
                                cnt[g][b] <= cnt[g][b] - 1'b1;
                            end
                        end
                        S_READING_AP, S_WRITING_AP: begin
                            // Auto-precharge chains straight into a full tRP dwell
                            if (cnt[g][b] == '0) begin
                                state[g][b] <= S_PRECHARGING;
                                cnt[g][b]   <= LD_RP;
                            end else begin
                                cnt[g][b] <= cnt[g][b] - 1'b1;
                            end
                        end
                        S_PRECHARGING, S_REFRESHING: begin
                            if (cnt[g][b] == '0) begin
                                state[g][b] <= S_IDLE;
                            end else begin
                                cnt[g][b] <= cnt[g][b] - 1'b1;
                            end
                        end
                        default: begin
                            state[g][b] <= S_IDLE;
                            cnt[g][b]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // State register drives the output code directly
    always_comb begin
        for (int g = 0; g < NBG; g++) begin
            for (int b = 0; b < NBA; b++) begin
                BankFSM[g][b] = state[g][b];
            end
        end
    end

endmodule

// File: tb/tb_timing_fsm.sv
// tb/tb_timing_fsm.sv - table-driven scoreboard bench for timing_fsm
module tb_timing_fsm;

    localparam logic [18:0] ACT = 19'h1 << 18;
    localparam logic [18:0] PR  = 19'h1 << 7;
    localparam logic [18:0] RD  = 19'h1 << 5;
    localparam logic [18:0] RDA = 19'h1 << 4;
    localparam logic [18:0] REF = 19'h1 << 3;
    localparam logic [18:0] WR  = 19'h1 << 1;
    localparam logic [18:0] WRA = 19'h1 << 0;
    localparam logic [18:0] NONE = 19'h0;

    logic        clk;
    logic        reset_n;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [18:0] commands;
    logic [4:0]  bank_fsm [0:3][0:3];

    timing_fsm dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bg       (bg),
        .ba       (ba),
        .commands (commands),
        .BankFSM  (bank_fsm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] cmd;
        int          g;
        int          b;
        int          off;
        int          cg;
        int          cb;
        logic [4:0]  exp;
        bit          others_idle;
        string       name;
    } vec_t;

    typedef struct {
        int         g;
        int         b;
        logic [4:0] exp;
        string      name;
    } sb_t;

    sb_t  sb_q [$];
    vec_t vecs [$];
    int   checks = 0;
    int   failures = 0;
    int   cur = 0;

    task automatic expect_bank(input int g, input int b, input logic [4:0] exp, input string name);
        sb_t e;
        e.g = g; e.b = b; e.exp = exp; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bank_fsm[e.g][e.b] !== e.exp) begin
                failures++;
                $display("FAIL %s bank[%0d][%0d] got=%02h exp=%02h at %0t",
                         e.name, e.g, e.b, bank_fsm[e.g][e.b], e.exp, $time);
            end
        end
    endtask

    // Drive a command for the next edge E, end at the negedge after E
    task automatic issue(input logic [18:0] c, input int g, input int b);
        commands = c;
        bg = 2'(g);
        ba = 2'(b);
        @(posedge clk);
        #1 commands = NONE;
        @(negedge clk);
        cur = 0;
    endtask

    // Move to the negedge after edge E+k
    task automatic goto(input int k);
        if (k > cur) begin
            repeat (k - cur) @(posedge clk);
            @(negedge clk);
            cur = k;
        end
    endtask

    task automatic add(input logic [18:0] c, input int g, input int b, input int off,
                       input int cg, input int cb, input logic [4:0] exp,
                       input bit oi, input string name);
        vec_t v;
        v.cmd = c; v.g = g; v.b = b; v.off = off; v.cg = cg; v.cb = cb;
        v.exp = exp; v.others_idle = oi; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        reset_n  = 1'b0;
        commands = NONE;
        bg = 2'd0;
        ba = 2'd0;

        add(ACT,  1, 1,  0, 1, 1, 5'h01, 1, "act_entry");
        add(NONE, 0, 0, 16, 1, 1, 5'h01, 1, "act_last");
        add(NONE, 0, 0, 17, 1, 1, 5'h03, 1, "act_done");
        add(WR,   1, 1,  0, 1, 1, 5'h12, 0, "wr_entry");
        add(NONE, 0, 0, 15, 1, 1, 5'h12, 0, "wr_hold");
        add(RD,   1, 1,  0, 1, 1, 5'h0b, 0, "rd_entry");
        add(WR,   1, 1,  0, 1, 1, 5'h12, 0, "wr_again");
        add(PR,   1, 1,  0, 1, 1, 5'h0a, 0, "pr_entry");
        add(NONE, 0, 0, 16, 1, 1, 5'h0a, 0, "pr_last");
        add(NONE, 0, 0, 17, 1, 1, 5'h00, 0, "pr_done");
        add(REF,  3, 3,  0, 1, 1, 5'h0d, 0, "ref_entry");
        add(NONE, 0, 0,  0, 2, 3, 5'h0d, 0, "ref_allbanks");
        add(NONE, 0, 0, 33, 1, 1, 5'h0d, 0, "ref_last");
        add(NONE, 0, 0, 34, 1, 1, 5'h00, 0, "ref_done");
        add(ACT,  0, 2,  0, 0, 2, 5'h01, 0, "wra_act");
        add(NONE, 0, 0, 17, 0, 2, 5'h03, 0, "wra_active");
        add(WRA,  0, 2,  0, 0, 2, 5'h13, 0, "wra_entry");
        add(NONE, 0, 0, 14, 0, 2, 5'h13, 0, "wra_last");
        add(NONE, 0, 0, 15, 0, 2, 5'h0a, 0, "wra_pre");
        add(NONE, 0, 0, 31, 0, 2, 5'h0a, 0, "wra_pre_last");
        add(NONE, 0, 0, 32, 0, 2, 5'h00, 0, "wra_done");
        add(ACT,  3, 0,  0, 3, 0, 5'h01, 0, "rda_act");
        add(NONE, 0, 0, 17, 3, 0, 5'h03, 0, "rda_active");
        add(RDA,  3, 0,  0, 3, 0, 5'h0c, 0, "rda_entry");
        add(NONE, 0, 0,  8, 3, 0, 5'h0c, 0, "rda_last");
        add(NONE, 0, 0,  9, 3, 0, 5'h0a, 0, "rda_pre");
        add(NONE, 0, 0, 25, 3, 0, 5'h0a, 0, "rda_pre_last");
        add(NONE, 0, 0, 26, 3, 0, 5'h00, 0, "rda_done");
        add(ACT,  2, 1,  0, 2, 1, 5'h01, 0, "ill_act");
        add(RD,   2, 1,  0, 2, 1, 5'h01, 0, "ill_rd_ignored");
        add(NONE, 0, 0, 15, 2, 1, 5'h01, 0, "ill_still_act");
        add(NONE, 0, 0, 16, 2, 1, 5'h03, 0, "ill_act_done");
        add(ACT | RD, 1, 2, 0, 1, 2, 5'h01, 0, "prio_act_over_rd");
        add(WR,   2, 1,  0, 2, 1, 5'h12, 0, "indep_wr");
        add(NONE, 0, 0,  0, 1, 2, 5'h01, 0, "indep_other");

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 4; g++)
            for (int b = 0; b < 4; b++)
                expect_bank(g, b, 5'h00, "reset_state");
        drain();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++)
            for (int b = 0; b < 4; b++)
                expect_bank(g, b, 5'h00, "idle_after_release");
        drain();

        foreach (vecs[i]) begin
            if (vecs[i].cmd != NONE) issue(vecs[i].cmd, vecs[i].g, vecs[i].b);
            goto(vecs[i].off);
            expect_bank(vecs[i].cg, vecs[i].cb, vecs[i].exp, vecs[i].name);
            if (vecs[i].others_idle) begin
                for (int g = 0; g < 4; g++)
                    for (int b = 0; b < 4; b++)
                        if (!(g == vecs[i].cg && b == vecs[i].cb))
                            expect_bank(g, b, 5'h00, "others_idle");
            end
            drain();
        end

        // Wait for every bank to settle to Idle, then abort a refresh with reset
        repeat (60) @(posedge clk);
        issue(PR, 2, 1);
        repeat (20) @(posedge clk);
        issue(PR, 1, 2);
        repeat (40) @(posedge clk);
        @(negedge clk);
        issue(REF, 0, 0);
        goto(5);
        expect_bank(0, 0, 5'h0d, "ref_before_reset");
        expect_bank(3, 3, 5'h0d, "ref_before_reset_b33");
        drain();
        #2 reset_n = 1'b0;
        #1;
        for (int g = 0; g < 4; g++)
            for (int b = 0; b < 4; b++)
                expect_bank(g, b, 5'h00, "async_reset_abort");
        drain();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        expect_bank(0, 0, 5'h00, "idle_after_abort");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
